hd_frame_rx: RTL and testbench

Serial front-end for the Hamming-distance datapath. Receives a bit-serial frame of two 7-bit Hamming(7,4) code words, deserializes it, and presents `code_word1`/`code_word2` in parallel with a valid/ready handshake to the downstream HD decode/compute stage. The output register is separate from the shift register, so the next frame is received while the current frame is still held. Frame-start and inactivity errors are flagged.

---
 rtl/hd_frame_rx.sv | 129 ++++++++++++
 tb/tb_hd_frame_rx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/hd_frame_rx.sv
// Bit-serial receiver for a frame of two 7-bit Hamming code words.
// Holds the last complete frame behind a valid/ready handshake while the next frame is shifting in.
module hd_frame_rx #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_bit,
    input  logic       in_sof,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [6:0] code_word1,
    output logic [6:0] code_word2,
    output logic       frame_err
);

    localparam int unsigned IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [13:0]     shift_q, shift_d;
    logic [IW-1:0]   idle_q, idle_d;
    logic            out_valid_q, out_valid_d;
    logic [6:0]      cw1_q, cw1_d;
    logic [6:0]      cw2_q, cw2_d;
    logic            frame_err_q, frame_err_d;
    logic            accept;
    logic            load;

    // The final bit is held off only while the output register is full and not draining.
    assign in_ready = !(cnt_q == 4'd13 && out_valid_q && !out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        idle_d      = idle_q;
        out_valid_d = out_valid_q;
        cw1_d       = cw1_q;
        cw2_d       = cw2_q;
        frame_err_d = 1'b0;
        load        = 1'b0;

        case (state_q)
            IDLE: begin
                idle_d = '0;
                if (accept && in_sof) begin
                    shift_d = {13'b0, in_bit};
                    cnt_d   = 4'd1;
                    state_d = RECV;
                end
            end
            RECV: begin
                if (accept) begin
                    idle_d = '0;
                    if (in_sof) begin
                        frame_err_d = 1'b1;
                        shift_d     = {13'b0, in_bit};
                        cnt_d       = 4'd1;
                    end else begin
                        shift_d = {shift_q[12:0], in_bit};
                        if (cnt_q == 4'd13) begin
                            load    = 1'b1;
                            cnt_d   = 4'd0;
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end else if (TIMEOUT != 0 && in_ready) begin
                    // Fires on the edge that completes the TIMEOUT-th idle cycle.
                    if (idle_q == IW'(TIMEOUT - 1)) begin
                        frame_err_d = 1'b1;
                        cnt_d       = 4'd0;
                        idle_d      = '0;
                        state_d     = IDLE;
                    end else begin
                        idle_d = idle_q + IW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            out_valid_d = 1'b1;
            cw1_d       = shift_d[13:7];
            cw2_d       = shift_d[6:0];
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            idle_q      <= '0;
            out_valid_q <= 1'b0;
            cw1_q       <= '0;
            cw2_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            idle_q      <= idle_d;
            out_valid_q <= out_valid_d;
            cw1_q       <= cw1_d;
            cw2_q       <= cw2_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign code_word1 = cw1_q;
    assign code_word2 = cw2_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_hd_frame_rx.sv
// Bench for hd_frame_rx: directed frames plus random traffic, all checked
// against a queue-based frame model of the receiver.
module tb_hd_frame_rx;

    localparam int unsigned TO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       in_sof = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [6:0] code_word1;
    logic [6:0] code_word2;
    logic       frame_err;

    hd_frame_rx #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .in_sof     (in_sof),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .code_word1 (code_word1),
        .code_word2 (code_word2),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: bits of the frame in progress plus the held output.
    int       m_bits[$];
    bit       m_active = 1'b0;
    int       m_idle = 0;
    bit       e_valid = 1'b0;
    bit       e_err = 1'b0;
    logic [6:0] e_w1 = '0;
    logic [6:0] e_w2 = '0;
    bit       armed = 1'b0;

    int         err_pulses = 0;
    int         valid_cycles = 0;
    logic [6:0] last_w1 = '0;
    logic [6:0] last_w2 = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cycle(input bit v, input bit b, input bit s, input bit r, input bit rs);
        bit rdy;
        bit acc;
        @(negedge clk);
        if (armed) begin
            check("out_valid", {31'b0, out_valid}, {31'b0, e_valid});
            check("frame_err", {31'b0, frame_err}, {31'b0, e_err});
            check("code_word1", {25'b0, code_word1}, {25'b0, e_w1});
            check("code_word2", {25'b0, code_word2}, {25'b0, e_w2});
            if (frame_err === 1'b1) err_pulses++;
            if (out_valid === 1'b1) begin
                valid_cycles++;
                last_w1 = code_word1;
                last_w2 = code_word2;
            end
        end
        rst = rs;
        in_valid = v;
        in_bit = b;
        in_sof = s;
        out_ready = r;
        #1;
        rdy = !(m_bits.size() == 13 && e_valid && !r);
        if (armed) check("in_ready", {31'b0, in_ready}, {31'b0, rdy});
        e_err = 1'b0;
        if (rs) begin
            m_bits.delete();
            m_active = 1'b0;
            m_idle = 0;
            e_valid = 1'b0;
            e_w1 = '0;
            e_w2 = '0;
            armed = 1'b1;
            return;
        end
        acc = v && rdy;
        if (e_valid && r) e_valid = 1'b0;
        if (acc && s) begin
            if (m_active) e_err = 1'b1;
            m_bits.delete();
            m_bits.push_back(int'(b));
            m_active = 1'b1;
            m_idle = 0;
        end else if (acc && m_active) begin
            m_bits.push_back(int'(b));
            m_idle = 0;
            if (m_bits.size() == 14) begin
                e_w1 = '0;
                e_w2 = '0;
                for (int k = 0; k < 7; k++) begin
                    if (m_bits[k] != 0) e_w1 = e_w1 | 7'(1 << (6 - k));
                    if (m_bits[k + 7] != 0) e_w2 = e_w2 | 7'(1 << (6 - k));
                end
                e_valid = 1'b1;
                m_bits.delete();
                m_active = 1'b0;
            end
        end else if (!acc && m_active && rdy && TO != 0) begin
            m_idle++;
            if (m_idle == int'(TO)) begin
                e_err = 1'b1;
                m_active = 1'b0;
                m_bits.delete();
                m_idle = 0;
            end
        end
    endtask

    task automatic send_bits(input logic [13:0] f, input int first, input int last, input bit r);
        for (int k = first; k <= last; k++) cycle(1'b1, f[13 - k], k == 0, r, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    int e0;
    int v0;
    int pct;
    logic [13:0] fa;
    logic [13:0] fb;

    initial begin
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Basic frame with downstream ready.
        e0 = err_pulses; v0 = valid_cycles;
        fa = 14'b1010101_0110011;
        send_bits(fa, 0, 13, 1'b1);
        idle(3);
        check("t1_w1", {25'b0, last_w1}, 32'h55);
        check("t1_w2", {25'b0, last_w2}, 32'h33);
        check("t1_valid_cycles", valid_cycles - v0, 1);
        check("t1_err", err_pulses - e0, 0);

        // Backpressure on the final bit of the second frame.
        send_bits(fa, 0, 13, 1'b0);
        fb = 14'b1111111_0000000;
        send_bits(fb, 0, 12, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        check("t2_w1", {25'b0, last_w1}, 32'h7f);
        check("t2_w2", {25'b0, last_w2}, 32'h00);

        // Start-of-frame reasserted mid-frame.
        e0 = err_pulses;
        send_bits(14'b1111111_1111111, 0, 4, 1'b1);
        send_bits(14'b0000001_1000000, 0, 13, 1'b1);
        idle(3);
        check("t3_err", err_pulses - e0, 1);
        check("t3_w1", {25'b0, last_w1}, 32'h01);
        check("t3_w2", {25'b0, last_w2}, 32'h40);

        // Inactivity timeout, then a clean frame.
        e0 = err_pulses; v0 = valid_cycles;
        send_bits(14'b1100110_0000000, 0, 5, 1'b1);
        idle(int'(TO) + 2);
        check("t4_err", err_pulses - e0, 1);
        check("t4_no_valid", valid_cycles - v0, 0);
        send_bits(14'b0110110_1001011, 0, 13, 1'b1);
        idle(3);
        check("t4_w1", {25'b0, last_w1}, 32'h36);
        check("t4_w2", {25'b0, last_w2}, 32'h4b);

        // Bits without start-of-frame in IDLE are ignored.
        e0 = err_pulses; v0 = valid_cycles;
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
        idle(2);
        check("t5_err", err_pulses - e0, 0);
        check("t5_valid", valid_cycles - v0, 0);

        // Reset mid-frame with a held output.
        send_bits(14'b0011001_1100110, 0, 13, 1'b0);
        send_bits(14'b1010101_1010101, 0, 9, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        e0 = err_pulses; v0 = valid_cycles;
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t6_rst_valid", valid_cycles - v0, 0);
        check("t6_rst_err", err_pulses - e0, 0);
        send_bits(14'b1000001_0111110, 0, 13, 1'b1);
        idle(3);
        check("t6_w1", {25'b0, last_w1}, 32'h41);
        check("t6_w2", {25'b0, last_w2}, 32'h3e);

        // Random traffic with varying input density so timeouts and restarts occur.
        for (int blk = 0; blk < 20; blk++) begin
            case (blk % 4)
                0: pct = 95;
                1: pct = 60;
                2: pct = 20;
                default: pct = 5;
            endcase
            for (int i = 0; i < 200; i++) begin
                cycle($urandom_range(0, 99) < pct,
                      1'($urandom_range(0, 1)),
                      $urandom_range(0, 99) < 6,
                      $urandom_range(0, 99) < 70,
                      $urandom_range(0, 499) == 0);
            end
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
